saturn_alu_field_sequencer: RTL
===============================

# saturn_alu_field_sequencer

Nibble-serial field engine that drives the read and write ports of the Saturn ALU register file. It accepts one field operation: COPY, CLEAR, INC or ADD, over a start/end nibble range. It walks the range one nibble per `i_phase_3` slot, reading source nibbles combinationally from the register file. It presents the result nibble and a write strobe to the register file's destination port in the same slot, and propagates carry between nibbles. It sits between the instruction decoder and the register file.

## Interface
- No parameters.
- `i_clk` input 1: core clock.
- `i_reset` input 1: synchronous, active-high reset.
- `i_stalled` input 1: freezes sequencing; no write or advance while high.
- `i_phase_3` input 1: nibble slot strobe; at most one nibble is processed per strobe.
- `i_start` input 1: launch request; sampled only in IDLE.
- `i_op` input 2: operation code; 0 = COPY, 1 = CLEAR, 2 = INC, 3 = ADD.
- `i_reg_a`, `i_reg_b`, `i_reg_dst` input 5 each: `ALU_REG_*` codes from def-alu.v.
- `i_field_start`, `i_field_end` input 4 each: first and last nibble index.
- `i_dec_mode` input 1: decimal ADD/INC request.
- `o_src_ptr` output 4: nibble pointer to the register file read port.
- `o_src_1`, `o_src_2` output 5: read register selects.
- `i_src_1_nbl`, `i_src_2_nbl` input 4: read data.
- `i_src_1_valid`, `i_src_2_valid` input 1: read-select validity.
- `o_dest_ptr` output 4: write nibble pointer; always equals `o_src_ptr`.
- `o_dest_1` output 5: write register select.
- `o_dest_1_nbl` output 4: write data.
- `o_dest_wr` output 1: write qualifier; the register file stores on the clock edge where this is high.
- `o_busy`, `o_done`, `o_error` output 1: status. `o_done` and `o_error` are 1-cycle pulses.
- `o_carry` output 1: final carry of the last operation.

## Operation
- States:
  - IDLE: when `i_start` is high, latch the op, the regs, `i_field_end` and `i_dec_mode`; set ptr = `i_field_start`; set carry = 1 for INC, else 0; go to RUN.
  - RUN: process nibbles as below.
  - DONE: assert `o_done`, then return to IDLE.
- Slot event = RUN & `i_phase_3` & !`i_stalled`.
- Per slot event, all combinational from the latched op and the current read data:
  - COPY: nbl = A.
  - CLEAR: nbl = 0.
  - INC: sum = A + carry.
  - ADD: sum = A + B + carry.
- Hex mode: nbl = sum[3:0], next carry = sum[4]. Sums are 5-bit, zero-extended.
- Decimal mode: if sum > 9, nbl = sum − 10 and carry = 1; otherwise nbl = sum and carry = 0.
- COPY and CLEAR leave carry at 0.
- On a slot event `o_dest_wr` = 1. At that edge, ptr advances by 1 modulo 16 and carry updates.
- If ptr == latched end at the slot event, go to DONE instead of advancing. The final carry is written to `o_carry`.
- Field length = ((end − start) mod 16) + 1. Start > end wraps 15→0. Start == end processes 1 nibble; start = 0, end = 15 processes 16 nibbles.
- `o_src_1` = A reg in RUN; `o_src_2` = B reg for ADD only. Otherwise both drive `ALU_REG_NONE`.
- `o_dest_1` = dst in RUN, else `ALU_REG_NONE`.
- Invalid operand: if a used source has valid = 0, or dst is not a register, at a slot event:
  - no write (`o_dest_wr` = 0);
  - `o_error` pulses on the next cycle;
  - go to IDLE, `o_carry` unchanged.
- `i_start` while not IDLE is ignored.

## Timing
- Reset values:
  - state IDLE; ptr 0; `o_busy`, `o_done`, `o_error`, `o_dest_wr` and `o_carry` all 0;
  - `o_dest_1_nbl` 0; register selects = `ALU_REG_NONE`.
- Reset mid-RUN aborts at the next edge. No further writes; `o_done` is not pulsed.
- `o_busy` is high from the cycle after `i_start` until DONE exits.
- Latency: N slot events for N nibbles. `o_done` is high in the cycle after the final write edge.
- `o_dest_wr` is combinational. It is never high outside RUN or while `i_stalled` is high.
- A stall held across `i_phase_3` drops that slot. Sequencing resumes at the next unstalled `i_phase_3`.

## Configuration
- `SATURN_ALU_DECIMAL_EN`:
  - Defined: `i_dec_mode` selects decimal correction for INC and ADD.
  - Undefined: `i_dec_mode` is ignored and all arithmetic is hex. No decimal logic is synthesized.

## Test plan
- COPY A→C, field 0..4, A = 0x12345: 5 writes at ptr 0..4 with nbl 5,4,3,2,1; `o_done` pulses once.
- ADD A+B→A hex, field 0..1, A = 0xFF, B = 0x01: writes 0 at ptr 0 and 0 at ptr 1; `o_carry` = 1.
- INC decimal (macro defined), field 0..2, A = 0x999: writes 0,0,0; `o_carry` = 1. With the macro undefined: writes A,9,9; `o_carry` = 0.
- Wrap: CLEAR, start 14, end 1: writes at ptr 14,15,0,1 only; 4 slot events.
- Stall: assert `i_stalled` on the 2nd `i_phase_3` of a 3-nibble COPY: no write in that slot; completes after 4 strobes.
- Error and reset: `i_src_1_valid` = 0 on the first slot → no `o_dest_wr`, one `o_error` pulse, back to IDLE. Reset asserted mid-ADD → outputs return to reset values, no `o_done`.

Source files
------------

// File: rtl/saturn_alu_field_sequencer.sv
// saturn_alu_field_sequencer: nibble-serial COPY/CLEAR/INC/ADD field engine driving the ALU register file ports.
// Optional decimal INC/ADD correction is enabled by defining SATURN_ALU_DECIMAL_EN.
module saturn_alu_field_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_stalled,
  input  logic       i_phase_3,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic [4:0] i_reg_a,
  input  logic [4:0] i_reg_b,
  input  logic [4:0] i_reg_dst,
  input  logic [3:0] i_field_start,
  input  logic [3:0] i_field_end,
  input  logic       i_dec_mode,
  output logic [3:0] o_src_ptr,
  output logic [4:0] o_src_1,
  output logic [4:0] o_src_2,
  input  logic [3:0] i_src_1_nbl,
  input  logic [3:0] i_src_2_nbl,
  input  logic       i_src_1_valid,
  input  logic       i_src_2_valid,
  output logic [3:0] o_dest_ptr,
  output logic [4:0] o_dest_1,
  output logic [3:0] o_dest_1_nbl,
  output logic       o_dest_wr,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic       o_carry
);
  localparam logic [4:0] REG_NONE = 5'd31;
  localparam logic [1:0] OP_COPY = 2'd0, OP_CLEAR = 2'd1, OP_ADD = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [1:0] op;
  logic [4:0] ra, rb, rd;
  logic [3:0] ptr, last, nbl, arith;
  logic carry, err, run, use_a, use_b, slot, bad, over, cy;
  logic [4:0] sum;
`ifdef SATURN_ALU_DECIMAL_EN
  logic dec;
`else
  logic unused_dec;
  assign unused_dec = i_dec_mode;
`endif
  always_comb begin
    run = state == RUN;
    use_a = op != OP_CLEAR;
    use_b = op == OP_ADD;
    slot = run & i_phase_3 & ~i_stalled;
    // a destination of NONE is not a real register and counts as an invalid operand
    bad = (use_a & ~i_src_1_valid) | (use_b & ~i_src_2_valid) | (rd == REG_NONE);
    sum = {1'b0, i_src_1_nbl} + (use_b ? {1'b0, i_src_2_nbl} : 5'd0) + {4'd0, carry};
`ifdef SATURN_ALU_DECIMAL_EN
    over = dec ? sum > 5'd9 : sum[4];
    arith = (dec & over) ? 4'(sum - 5'd10) : sum[3:0];
`else
    over = sum[4];
    arith = sum[3:0];
`endif
    nbl = op == OP_COPY ? i_src_1_nbl : op == OP_CLEAR ? 4'd0 : arith;
    cy = op[1] & over;
    o_src_ptr = ptr;
    o_dest_ptr = ptr;
    o_src_1 = run ? ra : REG_NONE;
    o_src_2 = run & use_b ? rb : REG_NONE;
    o_dest_1 = run ? rd : REG_NONE;
    o_dest_1_nbl = run ? nbl : 4'd0;
    o_dest_wr = slot & ~bad;
    o_busy = state != IDLE;
    o_done = state == DONE;
    o_error = err;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      ptr <= 4'd0;
      last <= 4'd0;
      carry <= 1'b0;
      o_carry <= 1'b0;
      err <= 1'b0;
      op <= OP_COPY;
      ra <= REG_NONE;
      rb <= REG_NONE;
      rd <= REG_NONE;
`ifdef SATURN_ALU_DECIMAL_EN
      dec <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          op <= i_op;
          ra <= i_reg_a;
          rb <= i_reg_b;
          rd <= i_reg_dst;
          last <= i_field_end;
          ptr <= i_field_start;
          carry <= i_op == 2'd2;
`ifdef SATURN_ALU_DECIMAL_EN
          dec <= i_dec_mode;
`endif
          state <= RUN;
        end
        RUN: if (slot) begin
          if (bad) begin
            err <= 1'b1;
            state <= IDLE;
          end else begin
            carry <= cy;
            if (ptr == last) begin
              o_carry <= cy;
              state <= DONE;
            end else ptr <= ptr + 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
